alu_lane_sequencer: RTL

Sequences one vector operation across a single shared scalar ALU in the execute stage, one lane per clock. Accepts a LANES-wide vector instruction through a valid/ready handshake and drives the ALU's operation select and operand inputs lane by lane. Captures each lane's result plus its neg/zero flags and returns the assembled vector and per-lane flag masks through a second valid/ready handshake. This lets the vector execute stage reuse one combinational ALU instead of replicating it per lane.

---
 rtl/alu_lane_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_lane_sequencer.sv
// Sequences one vector operation lane by lane through a single shared scalar ALU,
// collecting per-lane results and neg/zero flags into a result vector and masks.
module alu_lane_sequencer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [2:0]               op_sel,
    input  logic [LANES*DATA_W-1:0]  vec_a,
    input  logic [LANES*DATA_W-1:0]  vec_b,
    input  logic                     scalar_b_en,
    output logic [2:0]               alu_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_neg,
    input  logic                     alu_zero,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [LANES*DATA_W-1:0]  res_vec,
    output logic [LANES-1:0]         res_zero_mask,
    output logic [LANES-1:0]         res_neg_mask,
    output logic                     busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                    state;
    logic [2:0]                op_q;
    logic [LANES*DATA_W-1:0]   a_q;
    logic [LANES*DATA_W-1:0]   b_q;
    logic [LW-1:0]             lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            lane          <= '0;
            res_vec       <= '0;
            res_zero_mask <= '0;
            res_neg_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_q         <= op_sel;
                        a_q          <= vec_a;
                        b_q          <= scalar_b_en ? {LANES{vec_b[DATA_W-1:0]}} : vec_b;
                        lane         <= '0;
                        res_vec      <= '0;
                        res_neg_mask <= '0;
                        // NOP skips the ALU entirely and reports every lane as zero
                        if (op_sel == 3'b000) begin
                            res_zero_mask <= '1;
                            state         <= DONE;
                        end else begin
                            res_zero_mask <= '0;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    res_vec[lane*DATA_W +: DATA_W] <= alu_result;
                    res_zero_mask[lane]            <= alu_zero;
                    res_neg_mask[lane]             <= alu_neg;
                    if (lane == LAST) begin
                        state <= DONE;
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (!rst && state == ISSUE) begin
            alu_op = op_q;
            alu_a  = a_q[lane*DATA_W +: DATA_W];
            alu_b  = b_q[lane*DATA_W +: DATA_W];
        end
    end

    assign start_ready = !rst && (state == IDLE);
    assign res_valid   = !rst && (state == DONE);
    assign busy        = !rst && (state != IDLE);

endmodule
